// File: rtl/ld_pkg.sv
// ld_pkg: funct3 load encodings, FSM states and load size helpers
package ld_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} state_t;
  function automatic logic [3:0] ld_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction
  function automatic logic f3_illegal(input logic [2:0] f3, input int xlen);
    return f3 == 3'b111 || (xlen == 32 && (f3 == F3_LD || f3 == F3_LWU));
  endfunction
  function automatic logic crosses(input logic [2:0] off, input logic [2:0] f3, input int xlen);
    return ({2'b00, off} + {1'b0, ld_bytes(f3)}) > 5'(xlen / 8);
  endfunction
endpackage

// File: rtl/load_ext.sv
// load_ext: picks the addressed bytes out of a double word and sign/zero extends them
//   i_data   two consecutive memory words {word1, word0}
//   i_off    byte offset of the load inside word0
//   i_funct3 load type
//   o_data   aligned, extended result
module load_ext
  import ld_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_data,
  input  logic [2:0]        i_off,
  input  logic [2:0]        i_funct3,
  output logic [XLEN-1:0]   o_data
);
  logic [XLEN-1:0] lo, mask;
  logic [6:0] nbits;
  logic uns, sx;
  always_comb begin
    lo = XLEN'(i_data >> {i_off, 3'b000});
    nbits = (i_funct3 == F3_LB || i_funct3 == F3_LBU) ? 7'd8 :
            (i_funct3 == F3_LH || i_funct3 == F3_LHU) ? 7'd16 :
            (i_funct3 == F3_LW || i_funct3 == F3_LWU) ? 7'd32 : 7'd64;
    uns = i_funct3 == F3_LBU || i_funct3 == F3_LHU || i_funct3 == F3_LWU;
    // a shift by the full width yields zero, so the mask wraps to all ones for full-width loads
    mask = (XLEN'(1) << nbits) - XLEN'(1);
    // mask ^ (mask >> 1) isolates the sign bit position of the loaded field
    sx = ~uns & |(lo & (mask ^ (mask >> 1)));
    o_data = (lo & mask) | ({XLEN{sx}} & ~mask);
  end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: issues one or two aligned word reads per load and returns the aligned, extended result
//   i_ld_*    load request (valid/ready, byte address, funct3)
//   o_dmem_*  word-aligned read request, i_dmem_gnt accepts it, i_dmem_rvalid/rdata return data
//   o_rsp_*   result (valid/ready, data, fault for illegal funct3 or forbidden misalignment)
module load_align_unit
  import ld_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [XLEN-1:0] i_ld_addr,
  input  logic [2:0]      i_funct3,
  output logic            o_dmem_req,
  output logic [XLEN-1:0] o_dmem_addr,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_fault
);
  localparam int OB = XLEN == 64 ? 3 : 2;
  localparam logic [XLEN-1:0] WSTEP = XLEN'(XLEN / 8);
  state_t state_q, state_d;
  logic [XLEN-1:0] addr_q, w0_q, data_q, ext_data;
  logic [2:0] f3_q;
  logic fault_q, accept, bad_in, cross_q, fill, in_w1;
  always_comb begin
    accept = i_ld_valid && state_q == S_IDLE;
    bad_in = f3_illegal(i_funct3, XLEN) || (!MISALIGN_EN && crosses(3'(i_ld_addr[OB-1:0]), i_funct3, XLEN));
    cross_q = crosses(3'(addr_q[OB-1:0]), f3_q, XLEN);
    in_w1 = state_q == S_WAIT1;
    fill = i_dmem_rvalid && ((state_q == S_WAIT0 && !cross_q) || in_w1);
  end
  load_ext #(.XLEN(XLEN)) u_ext (
    .i_data  ({in_w1 ? i_dmem_rdata : '0, in_w1 ? w0_q : i_dmem_rdata}),
    .i_off   (3'(addr_q[OB-1:0])),
    .i_funct3(f3_q),
    .o_data  (ext_data)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_ld_valid) state_d = bad_in ? S_RESP : S_REQ0;
      S_REQ0:  if (i_dmem_gnt) state_d = S_WAIT0;
      S_WAIT0: if (i_dmem_rvalid) state_d = cross_q ? S_REQ1 : S_RESP;
      S_REQ1:  if (i_dmem_gnt) state_d = S_WAIT1;
      S_WAIT1: if (i_dmem_rvalid) state_d = S_RESP;
      S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    o_ld_ready = state_q == S_IDLE;
    o_dmem_req = state_q == S_REQ0 || state_q == S_REQ1;
    o_dmem_addr = {addr_q[XLEN-1:OB], {OB{1'b0}}} + (state_q == S_REQ1 ? WSTEP : '0);
    o_rsp_valid = state_q == S_RESP;
    o_rsp_data = data_q;
    o_rsp_fault = fault_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      addr_q <= '0;
      f3_q <= '0;
      w0_q <= '0;
      data_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= i_ld_addr;
        f3_q <= i_funct3;
        data_q <= '0;
        fault_q <= bad_in;
      end
      if (state_q == S_WAIT0 && i_dmem_rvalid) w0_q <= i_dmem_rdata;
      if (fill) data_q <= ext_data;
    end
endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter MISALIGN_EN, default 1; 1 = split word-crossing loads, 0 = fault them.
REQ-003 SHALL have port i_clk  input  1  clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ld_valid  input  1  load request valid.
REQ-006 SHALL have port o_ld_ready  output  1  unit can accept a request.
REQ-007 SHALL have port i_ld_addr  input  XLEN  byte address.
REQ-008 SHALL have port i_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-009 SHALL have port o_dmem_req  output  1  memory read request.
REQ-010 SHALL have port o_dmem_addr  output  XLEN  word-aligned address (low log2(XLEN/8) bits zero).
REQ-011 SHALL have port i_dmem_gnt  input  1  request accepted this cycle.
REQ-012 SHALL have port i_dmem_rvalid  input  1  read data valid.
REQ-013 SHALL have port i_dmem_rdata  input  XLEN  read word.
REQ-014 SHALL have port o_rsp_valid  output  1  result valid.
REQ-015 SHALL have port i_rsp_ready  input  1  consumer accepts result.
REQ-016 SHALL have port o_rsp_data  output  XLEN  aligned, extended result.
REQ-017 SHALL have port o_rsp_fault  output  1  misaligned (MISALIGN_EN=0) or illegal funct3.

Function
REQ-018 SHALL implement FSM IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; one outstanding load.
REQ-019 o_ld_ready SHALL be 1 only in IDLE; accepted request (valid&&ready) latches addr and funct3.
REQ-020 Illegal funct3 (111; 011/110 when XLEN=32) or misaligned crossing with MISALIGN_EN=0: IDLE->RESP, fault=1, data=0, no dmem request.
REQ-021 Otherwise IDLE->REQ0; o_dmem_req=1, addr=aligned(addr), held stable until i_dmem_gnt; on gnt ->WAIT0.
REQ-022 WAIT0 captures i_dmem_rdata on i_dmem_rvalid; -> REQ1 if access crosses word boundary (offset+size > XLEN/8), else ->RESP.
REQ-023 REQ1/WAIT1 as REQ0/WAIT0 with addr = aligned(addr)+XLEN/8, wrapping modulo 2^XLEN.
REQ-024 Result = low size bytes of ({word1,word0} >> 8*offset), sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU); LD and XLEN=32 LW pass unchanged.
REQ-025 RESP holds o_rsp_valid=1 and stable data/fault until i_rsp_ready; then ->IDLE; no new request accepted in same cycle.
REQ-026 i_dmem_rvalid outside WAIT0/WAIT1 and i_dmem_gnt outside REQ0/REQ1 SHALL be ignored.
REQ-027 Minimum latency, gnt same cycle and rvalid next cycle: accept T, req T+1, rvalid T+2, rsp_valid T+3 (+2 when split).

Reset
REQ-028 i_rst_n low SHALL asynchronously force IDLE; o_dmem_req=0, o_rsp_valid=0, o_rsp_fault=0, o_rsp_data=0, o_dmem_addr=0, o_ld_ready=1 after release.
REQ-029 Reset mid-operation SHALL drop the load with no response; late rvalid after release ignored.

Structure
REQ-030 Shared package ld_pkg SHALL hold funct3 load constants and the FSM state enum.
REQ-031 Combinational extension SHALL be sub-module load_ext (parametrised XLEN: size select, sign/zero extend).

Verification
REQ-032 XLEN=32, LB @0x1003, rdata 0x80FF_1234 -> one request addr 0x1000, rsp 0xFFFF_FF80, fault 0.
REQ-033 LHU @0x1002, rdata 0xBEEF_0000 -> rsp 0x0000_BEEF, exactly one dmem request.
REQ-034 MISALIGN_EN=1, LW @0x1001, word 0x1000=0x4433_2211, 0x1004=0x8877_6655 -> requests 0x1000 then 0x1004, rsp 0x5544_3322.
REQ-035 MISALIGN_EN=0, LH @0x1003 -> no o_dmem_req, rsp_valid at T+1, fault 1, data 0.
REQ-036 gnt low 3 cycles, rsp_ready low 2 cycles -> o_dmem_addr and o_rsp_data stable throughout, single response.
REQ-037 Reset asserted in WAIT1, rvalid pulsed after release -> no rsp_valid, o_ld_ready 1; XLEN=64 LWU @0x8, rdata 0xDEAD_BEEF_0000_0000 >>0 -> rsp 0x0000_0000_0000_0000 sanity.
